// File: rtl/ram_arb_pkg.sv
// Shared constants, FSM state encodings and request bundle for the
// two-master RAM arbiter.
package ram_arb_pkg;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [AW-1:0] ADDR_MAX = AW'(2047);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_2p_rr_pick2.sv
// Combinational two-way round-robin selector: prio breaks ties, a lone
// requester always wins.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant,
  output logic       gnt_any
);

  assign gnt_any = |valid;
  assign grant   = (valid == 2'b11) ? prio : valid[1];

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter and sequencer placing two masters in front of one
// 2048 x 16 single-port SRAM, with out-of-range address screening.
module ram_arbiter_2p
  import ram_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_write,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      req_done,
  output logic            req_error,
  output logic [DW-1:0]   req_rdata,
  output logic            ram_valid,
  output logic            ram_write,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic            ram_ready,
  input  logic            ram_error,
  input  logic [DW-1:0]   ram_rdata
);

  logic [1:0] state;
  logic       prio;
  logic       gnt;
  logic       err;
  req_t       lreq;
  req_t       sel;
  logic       pick;
  logic       pick_any;

  rr_pick2 u_pick (
    .valid   (req_valid),
    .prio    (prio),
    .grant   (pick),
    .gnt_any (pick_any)
  );

  // NOTE: every field gets a value on every path, so no latch is inferred.
  always_comb begin
    sel.write = req_write[pick];
    sel.addr  = pick ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
    sel.wdata = pick ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  end

  // Moore outputs: the RAM port is driven straight from the latched request.
  assign ram_valid = (state == ISSUE);
  assign ram_write = lreq.write;
  assign ram_addr  = lreq.addr;
  assign ram_wdata = lreq.wdata;
  assign req_done  = (state == RESP) ? onehot2(gnt) : 2'b00;
  assign req_error = (state == RESP) & err;

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      gnt       <= 1'b0;
      err       <= 1'b0;
      lreq      <= '0;
      req_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt  <= pick;
            prio <= ~pick;
            lreq <= sel;
            if (sel.addr > ADDR_MAX) begin
              err   <= 1'b1;
              state <= RESP;
            end else begin
              err   <= 1'b0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          req_rdata <= lreq.write ? '0 : ram_rdata;
          err       <= ram_error | ~ram_ready;
          state     <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural 2048 x 16 RAM
// whose contents are cleared by the same reset.
module tb_ram_arbiter_2p;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_done;
  logic        req_error;
  logic [15:0] req_rdata;
  logic        ram_valid, ram_write;
  logic [15:0] ram_addr, ram_wdata;
  logic        ram_ready, ram_error;
  logic [15:0] ram_rdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int both_cnt = 0;
  int spurious = 0;
  int rv0;

  op_t         ops [2][2];
  int          nops [2];
  int          dly [2];
  int          ord [4];
  int          dcyc [4];
  logic [15:0] rd_rec [2][2];
  logic        er_rec [2][2];
  int          start_cyc;

  logic [15:0] mem [0:2047];

  ram_arbiter_2p dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_error (req_error),
    .req_rdata (req_rdata),
    .ram_valid (ram_valid),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_ready (ram_ready),
    .ram_error (ram_error),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered ready/error/rdata, one access per valid cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
      ram_ready <= 1'b0;
      ram_error <= 1'b0;
      ram_rdata <= '0;
    end else if (ram_valid) begin
      ram_ready <= 1'b1;
      if (ram_addr > 16'd2047) begin
        ram_error <= 1'b1;
      end else begin
        ram_error <= 1'b0;
        if (ram_write) mem[ram_addr[10:0]] <= ram_wdata;
        else           ram_rdata <= mem[ram_addr[10:0]];
      end
    end else begin
      ram_ready <= 1'b0;
      ram_error <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (ram_valid)          rv_cnt   <= rv_cnt + 1;
    if (req_done == 2'b11)  both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input int m, input op_t o);
    req_write[m]          = o.w;
    req_addr[m*16 +: 16]  = o.a;
    req_wdata[m*16 +: 16] = o.d;
    req_valid[m]          = 1'b1;
  endtask

  // Runs the queued ops of both masters; each master advances to its next
  // op (or drops valid) in the cycle its done is seen.
  task automatic run_dual();
    int idx [2];
    int n;
    int total;
    idx[0] = 0;
    idx[1] = 0;
    n      = 0;
    total  = nops[0] + nops[1];
    @(negedge clk);
    start_cyc = cyc;
    for (int m = 0; m < 2; m++)
      if (nops[m] > 0 && dly[m] == 0) drive_op(m, ops[m][0]);
    for (int t = 1; t <= 60 && n < total; t++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (req_done[m]) begin
          if (idx[m] >= nops[m]) begin
            spurious++;
          end else begin
            ord[n]             = m;
            dcyc[n]            = cyc;
            rd_rec[m][idx[m]]  = req_rdata;
            er_rec[m][idx[m]]  = req_error;
            n++;
            idx[m]++;
            if (idx[m] < nops[m]) drive_op(m, ops[m][idx[m]]);
            else                  req_valid[m] = 1'b0;
          end
        end
      end
      for (int m = 0; m < 2; m++)
        if (nops[m] > 0 && dly[m] == t) drive_op(m, ops[m][0]);
    end
    check("all_done_in_budget", n, total);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_done",   {30'd0, req_done}, 0);
    check("rst_ramv",   ram_valid, 0);
    check("rst_raddr",  ram_addr, 0);
    check("rst_rdata",  req_rdata, 0);
    rst = 1'b0;

    // A writes 5 = 0x00AA then reads it back
    rv0 = rv_cnt;
    nops = '{1, 0}; dly = '{0, 0};
    ops[0][0] = '{1'b1, 16'd5, 16'h00AA};
    run_dual();
    check("wr5_err", er_rec[0][0], 0);
    check("wr5_latency", dcyc[0] - start_cyc + 1, 4);
    ops[0][0] = '{1'b0, 16'd5, 16'h0000};
    run_dual();
    check("rd5_data", rd_rec[0][0], 16'h00AA);
    check("rd5_err", er_rec[0][0], 0);
    check("rd5_latency", dcyc[0] - start_cyc + 1, 4);
    check("t1_ram_valid_pulses", rv_cnt - rv0, 2);

    // B reads 2048 (rejected), then 2047 (legal)
    rv0 = rv_cnt;
    nops = '{0, 1};
    ops[1][0] = '{1'b0, 16'd2048, 16'h0000};
    run_dual();
    check("rd2048_err", er_rec[1][0], 1);
    check("rd2048_latency", dcyc[0] - start_cyc + 1, 2);
    check("rd2048_no_ram", rv_cnt - rv0, 0);
    ops[1][0] = '{1'b0, 16'd2047, 16'h0000};
    run_dual();
    check("rd2047_err", er_rec[1][0], 0);
    check("rd2047_data", rd_rec[1][0], 16'h0000);

    // Continuous contention: A and B alternate
    nops = '{2, 2}; dly = '{0, 0};
    ops[0][0] = '{1'b1, 16'd1, 16'd10};
    ops[0][1] = '{1'b0, 16'd1, 16'd0};
    ops[1][0] = '{1'b1, 16'd2, 16'd20};
    ops[1][1] = '{1'b0, 16'd2, 16'd0};
    run_dual();
    check("rr_ord0", ord[0], 0);
    check("rr_ord1", ord[1], 1);
    check("rr_ord2", ord[2], 0);
    check("rr_ord3", ord[3], 1);
    check("rr_gap01", dcyc[1] - dcyc[0], 4);
    check("rr_gap12", dcyc[2] - dcyc[1], 4);
    check("rr_gap23", dcyc[3] - dcyc[2], 4);
    check("rr_rd1", rd_rec[0][1], 16'd10);
    check("rr_rd2", rd_rec[1][1], 16'd20);
    check("rr_err", {er_rec[0][0], er_rec[0][1], er_rec[1][0], er_rec[1][1]}, 0);

    // Boundary addresses
    nops = '{2, 0};
    ops[0][0] = '{1'b1, 16'd0,    16'hFFFF};
    ops[0][1] = '{1'b1, 16'd2047, 16'h1234};
    run_dual();
    ops[0][0] = '{1'b0, 16'd0,    16'h0000};
    ops[0][1] = '{1'b0, 16'd2047, 16'h0000};
    run_dual();
    check("bnd_rd0", rd_rec[0][0], 16'hFFFF);
    check("bnd_rd2047", rd_rec[0][1], 16'h1234);
    check("bnd_err", {er_rec[0][0], er_rec[0][1]}, 0);

    // Reset during WAIT of an A read
    @(negedge clk);
    drive_op(0, '{1'b0, 16'd5, 16'hBEEF});
    @(negedge clk);
    check("abort_issue_valid", ram_valid, 1);
    @(negedge clk);
    check("abort_wait_valid", ram_valid, 0);
    check("abort_wait_addr", ram_addr, 16'd5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", {30'd0, req_done}, 0);
    check("abort_error", req_error, 0);
    check("abort_rdata", req_rdata, 0);
    check("abort_ram_outs", {ram_valid, ram_write, ram_addr, ram_wdata}, 0);
    rst = 1'b0;
    req_valid = '0;
    nops = '{1, 1}; dly = '{0, 0};
    ops[0][0] = '{1'b0, 16'd5, 16'h0000};
    ops[1][0] = '{1'b0, 16'd1, 16'h0000};
    run_dual();
    check("post_rst_prio_a_first", ord[0], 0);
    check("post_rst_rd5", rd_rec[0][0], 16'h0000);
    check("post_rst_rd1", rd_rec[1][0], 16'h0000);

    // A holds a request, B arrives one cycle later
    dly = '{0, 1};
    ops[0][0] = '{1'b1, 16'd3, 16'h0033};
    ops[1][0] = '{1'b0, 16'd3, 16'h0000};
    run_dual();
    check("late_b_ord0", ord[0], 0);
    check("late_b_latency_a", dcyc[0] - start_cyc + 1, 4);
    check("late_b_gap", dcyc[1] - dcyc[0], 4);
    check("late_b_rd3", rd_rec[1][0], 16'h0033);

    @(negedge clk);
    check("no_spurious_done", spurious, 0);
    check("no_dual_done", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
